dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-requester arbiter and sequencer in front of the single-port, word-wide data memory. It shares the memory between the core load/store unit (port 0) and the debug/DMA master (port 1) through a req/gnt/rvalid handshake. Byte-enabled stores become a read-modify-write (RMW) sequence, because the memory only supports full-word writes. The block sits between the requesters and the memory instance and drives all of the memory's enable, write, address and write-data inputs.

## Interface
Parameters:
- ADDR_WIDTH, 8, word address width; matches the memory.
- DATA_WIDTH, 32, word width; must be a multiple of 8. NBE = DATA_WIDTH/8.

Ports (port n of a packed vector occupies slice n):
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- req_i  in  2  request per port; held until granted.
- we_i  in  2  1 = store, 0 = load.
- be_i  in  2*NBE  byte enables; ignored for loads.
- addr_i  in  2*ADDR_WIDTH  word address.
- wdata_i  in  2*DATA_WIDTH  store data.
- gnt_o  out  2  one-hot grant; request is accepted in this cycle.
- rvalid_o  out  2  response valid per port.
- rdata_o  out  DATA_WIDTH  load data, shared by both ports and qualified by rvalid_o.
- mem_en_o, mem_wr_o  out  1 each  memory enable and write.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_rdata_i  in  DATA_WIDTH  memory read data, registered with 1-cycle latency; a read during a write returns the old word.

## Operation
FSM states:
- IDLE: accepts a new request this cycle.
- RMW_WR: writes the merged word; no grant is given.

Request classes once granted in IDLE:
- Load: mem_en=1, mem_wr=0, mem_addr=addr. Next state IDLE.
- Full store (be all ones): mem_en=1, mem_wr=1, mem_wdata=wdata. Next state IDLE.
- Partial store (be nonzero, not all ones): the read is issued now. Address, be and wdata are latched. Next state RMW_WR.
- Empty store (be == 0): granted, with no memory write and mem_en=0. It is still acknowledged.

RMW_WR:
- Drives mem_en=1, mem_wr=1 at the latched address.
- Merged word: byte k = be[k] ? wdata byte k : mem_rdata_i byte k.
- Next state IDLE.

Arbitration:
- Only in IDLE, and only when at least one request is asserted.
- Selection rule: see Configuration.
- gnt_o is combinational from req_i and the state. At most one bit is set.

Responses:
- rvalid_o goes high for exactly one cycle per grant, on the owning port.
- rdata_o carries mem_rdata_i for loads and is 0 for store responses.

Other rules:
- Requester-side inputs need only be stable in the grant cycle.
- Port isolation: a port's inputs never affect the other port's transaction.

## Timing
Grant in cycle T. Response timing by request class:
- Load: rvalid and rdata in T+1.
- Full or empty store: rvalid in T+1. The memory is written at the T→T+1 edge.
- Partial store: RMW_WR occupies T+1, rvalid in T+2. The memory is written at the T+1→T+2 edge.

Throughput:
- Back-to-back grants are allowed in T+1 after a load or full store. A single port can therefore sustain one access per cycle.
- After a partial store, the next grant is no earlier than T+2.
- A load to the same address in the cycle after a full store returns the new data.

Reset:
- While rst_i is high: state=IDLE, gnt_o=0, rvalid_o=0, rdata_o=0, mem_en_o=0, mem_wr_o=0, mem_addr_o=0, mem_wdata_o=0, RR pointer favours port 0.
- Reset asserted during RMW_WR aborts the write. Memory is untouched and no rvalid is produced.

Simultaneous events:
- A response for one transaction and a grant for the next can coincide in the same cycle, including on the same port.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. The pointer names the preferred port. After any grant, the pointer moves to the other port. A port that requests continuously is granted at least every other access opportunity.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins. No pointer register exists.

## Test plan
- Load after init: store 0xDEADBEEF (be=1111) to 0x10 from port 0, then load 0x10 → gnt at T, rvalid[0] at T+1, rdata=0xDEADBEEF.
- Partial store: word 0x11223344 at 0x20, then port 1 store be=0101, wdata=0xAABBCCDD → mem write in T+1 with 0x11BB33DD. gnt blocked in T+1, rvalid[1] in T+2.
- Contention: both ports request loads continuously for 6 cycles. With RR, grants alternate 0,1,0,1,0,1. Without the macro, all 6 grants go to port 0.
- Empty store: be=0000 to 0x30 holding 0x55 → rvalid in T+1, mem_en stays 0, word still 0x55.
- Back-to-back: full store 0x12345678 to 0x40 at T, load 0x40 at T+1 → rdata=0x12345678 at T+2.
- Reset in RMW_WR: assert rst_i during RMW_WR → all outputs 0 and the target word unchanged. After release, the first grant goes to port 0 when both ports request.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares a single-port, word-wide data memory between the
// load/store unit (port 0) and the debug/DMA master (port 1). Byte-enabled
// stores are turned into a read-modify-write, because the memory only takes
// full-word writes.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration;
// the default build uses fixed priority with port 0 always winning.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                req_i,
  input  logic [1:0]                we_i,
  input  logic [2*(DATA_WIDTH/8)-1:0] be_i,
  input  logic [2*ADDR_WIDTH-1:0]   addr_i,
  input  logic [2*DATA_WIDTH-1:0]   wdata_i,
  output logic [1:0]                gnt_o,
  output logic [1:0]                rvalid_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      mem_en_o,
  output logic                      mem_wr_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int NBE = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] rmw_addr_q;
  logic [NBE-1:0]        rmw_be_q;
  logic [DATA_WIDTH-1:0] rmw_wdata_q;
  logic                  rmw_port_q;
  logic [1:0]            rvalid_q;
  logic                  resp_load_q;

  logic [1:0]            gnt;
  logic                  sel_port;
  logic                  sel_we;
  logic [NBE-1:0]        sel_be;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_full;
  logic                  sel_partial;
  logic [DATA_WIDTH-1:0] merged;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr_q;

  // Round-robin grant: the pointer picks the winner only on contention.
  always_comb begin
    gnt = '0;
    if (!rst_i && state_q == IDLE) begin
      unique case (req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_ptr_q ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
    end
  end

  // After any grant, prefer the port that was not just served.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= 1'b0;
    end else if (|gnt) begin
      rr_ptr_q <= gnt[0];
    end
  end
`else
  // Fixed-priority grant: port 0 always wins.
  always_comb begin
    gnt = '0;
    if (!rst_i && state_q == IDLE) begin
      if (req_i[0]) begin
        gnt = 2'b01;
      end else if (req_i[1]) begin
        gnt = 2'b10;
      end
    end
  end
`endif

  assign gnt_o = gnt;

  // Only the granted port's fields are ever looked at, which keeps the
  // ports isolated from each other.
  assign sel_port    = gnt[1];
  assign sel_we      = sel_port ? we_i[1] : we_i[0];
  assign sel_be      = sel_port ? be_i[2*NBE-1:NBE] : be_i[NBE-1:0];
  assign sel_addr    = sel_port ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
  assign sel_wdata   = sel_port ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
  assign sel_full    = &sel_be;
  assign sel_partial = (|sel_be) && !sel_full;

  // Byte merge of the latched store data over the word read back in RMW_WR.
  always_comb begin
    merged = '0;
    for (int unsigned k = 0; k < NBE; k++) begin
      merged[8*k +: 8] = rmw_be_q[k] ? rmw_wdata_q[8*k +: 8] : mem_rdata_i[8*k +: 8];
    end
  end

  // Memory command: merged write in RMW_WR, otherwise driven by the grant.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!rst_i) begin
      if (state_q == RMW_WR) begin
        mem_en_o    = 1'b1;
        mem_wr_o    = 1'b1;
        mem_addr_o  = rmw_addr_q;
        mem_wdata_o = merged;
      end else if (|gnt) begin
        if (!sel_we) begin
          mem_en_o   = 1'b1;
          mem_addr_o = sel_addr;
        end else if (sel_full) begin
          mem_en_o    = 1'b1;
          mem_wr_o    = 1'b1;
          mem_addr_o  = sel_addr;
          mem_wdata_o = sel_wdata;
        end else if (sel_partial) begin
          mem_en_o   = 1'b1;
          mem_addr_o = sel_addr;
        end
      end
    end
  end

  // Sequencer: RMW latching, state transitions and registered responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rmw_addr_q  <= '0;
      rmw_be_q    <= '0;
      rmw_wdata_q <= '0;
      rmw_port_q  <= 1'b0;
      rvalid_q    <= '0;
      resp_load_q <= 1'b0;
    end else begin
      rvalid_q    <= '0;
      resp_load_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|gnt) begin
            if (sel_we && sel_partial) begin
              state_q     <= RMW_WR;
              rmw_addr_q  <= sel_addr;
              rmw_be_q    <= sel_be;
              rmw_wdata_q <= sel_wdata;
              rmw_port_q  <= sel_port;
            end else begin
              rvalid_q    <= gnt;
              resp_load_q <= !sel_we;
            end
          end
        end
        RMW_WR: begin
          state_q  <= IDLE;
          rvalid_q <= rmw_port_q ? 2'b10 : 2'b01;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rvalid_o = rvalid_q;
  // The memory's registered read lines up with the response cycle of a load.
  assign rdata_o  = (resp_load_q && (|rvalid_q)) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [1:0]    we;
  logic [7:0]    be;
  logic [15:0]   addr;
  logic [63:0]   wdata;
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [31:0]   rdata;
  logic          mem_en;
  logic          mem_wr;
  logic [7:0]    mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0]   tb_mem [256];

  int tests = 0;
  int fails = 0;

  dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .mem_en_o(mem_en), .mem_wr_o(mem_wr),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory, 1-cycle registered read, read-during-write returns old word.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
      mem_rdata <= tb_mem[mem_addr];
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req = '0;
  endtask

  task automatic drive(input int p, input logic w, input logic [3:0] b,
                       input logic [7:0] a, input logic [31:0] d);
    req[p]          = 1'b1;
    we[p]           = w;
    be[p*4 +: 4]    = b;
    addr[p*8 +: 8]  = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 1'b1, 4'hF, 8'h11, 32'hFFFF_FFFF);
    drive(1, 1'b0, 4'h0, 8'h22, 32'h0);
    #1;
    tests++;
    if ({gnt, rvalid} !== 4'b0000) begin
      fails++; $display("FAIL reset_gnt_rvalid: got %b required 0000", {gnt, rvalid});
    end
    tests++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, rdata} !== 74'd0) begin
      fails++; $display("FAIL reset_mem_outputs: en=%b wr=%b addr=%h wdata=%h rdata=%h required all 0",
                        mem_en, mem_wr, mem_addr, mem_wdata, rdata);
    end
    step; step;
    tests++;
    if ({gnt, rvalid, mem_en} !== 5'b0) begin
      fails++; $display("FAIL reset_held: got %b required 00000", {gnt, rvalid, mem_en});
    end
    idle;
    rst = 1'b0;
    step;
  endtask

  task automatic test_load_after_store;
    drive(0, 1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF);
    #1;
    tests++;
    if ({gnt, mem_en, mem_wr, mem_addr, mem_wdata} !== {2'b01, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL full_store_cmd: gnt=%b en=%b wr=%b addr=%h wdata=%h required 01 1 1 10 deadbeef",
                        gnt, mem_en, mem_wr, mem_addr, mem_wdata);
    end
    step; idle;
    tests++;
    if ({rvalid, rdata} !== {2'b01, 32'h0}) begin
      fails++; $display("FAIL full_store_resp: rvalid=%b rdata=%h required 01 0", rvalid, rdata);
    end
    drive(0, 1'b0, 4'h0, 8'h10, 32'h0);
    #1;
    tests++;
    if ({gnt, mem_en, mem_wr, mem_addr} !== {2'b01, 1'b1, 1'b0, 8'h10}) begin
      fails++; $display("FAIL load_cmd: gnt=%b en=%b wr=%b addr=%h required 01 1 0 10", gnt, mem_en, mem_wr, mem_addr);
    end
    step; idle;
    tests++;
    if ({rvalid, rdata} !== {2'b01, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL load_resp: rvalid=%b rdata=%h required 01 deadbeef", rvalid, rdata);
    end
  endtask

  task automatic test_partial_store;
    drive(0, 1'b1, 4'hF, 8'h20, 32'h1122_3344);
    step; idle;
    drive(1, 1'b1, 4'b0101, 8'h20, 32'hAABB_CCDD);
    #1;
    tests++;
    if ({gnt, mem_en, mem_wr, mem_addr} !== {2'b10, 1'b1, 1'b0, 8'h20}) begin
      fails++; $display("FAIL rmw_read_cmd: gnt=%b en=%b wr=%b addr=%h required 10 1 0 20", gnt, mem_en, mem_wr, mem_addr);
    end
    step; idle;
    drive(0, 1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    tests++;
    if ({gnt, rvalid, mem_en, mem_wr, mem_addr, mem_wdata} !== {2'b00, 2'b00, 1'b1, 1'b1, 8'h20, 32'h11BB_33DD}) begin
      fails++; $display("FAIL rmw_write_cmd: gnt=%b rvalid=%b en=%b wr=%b addr=%h wdata=%h required 00 00 1 1 20 11bb33dd",
                        gnt, rvalid, mem_en, mem_wr, mem_addr, mem_wdata);
    end
    step;
    tests++;
    if ({rvalid, rdata, gnt} !== {2'b10, 32'h0, 2'b01}) begin
      fails++; $display("FAIL rmw_resp: rvalid=%b rdata=%h gnt=%b required 10 0 01", rvalid, rdata, gnt);
    end
    tests++;
    if (tb_mem[8'h20] !== 32'h11BB_33DD) begin
      fails++; $display("FAIL rmw_mem_word: got %h required 11bb33dd", tb_mem[8'h20]);
    end
    step; idle;
    tests++;
    if (rvalid !== 2'b01) begin
      fails++; $display("FAIL rmw_next_resp: rvalid=%b required 01", rvalid);
    end
  endtask

  task automatic test_contention;
    logic [1:0] exp_gnt;
    logic [1:0] prev_gnt;
    // A lone port-1 grant leaves the round-robin preference on port 0.
    drive(1, 1'b0, 4'h0, 8'h20, 32'h0);
    step; idle;
    drive(0, 1'b0, 4'h0, 8'h10, 32'h0);
    drive(1, 1'b0, 4'h0, 8'h20, 32'h0);
    prev_gnt = 2'b00;
    for (int i = 0; i < 6; i++) begin
      #1;
`ifdef DMEM_ARB_RR_EN
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_gnt = 2'b01;
`endif
      tests++;
      if (gnt !== exp_gnt) begin
        fails++; $display("FAIL contention_gnt[%0d]: got %b required %b", i, gnt, exp_gnt);
      end
      if (i > 0) begin
        tests++;
        if ({rvalid, rdata} !== {prev_gnt, prev_gnt[1] ? 32'h11BB_33DD : 32'hDEAD_BEEF}) begin
          fails++; $display("FAIL contention_resp[%0d]: rvalid=%b rdata=%h required %b %h", i, rvalid, rdata,
                            prev_gnt, prev_gnt[1] ? 32'h11BB_33DD : 32'hDEAD_BEEF);
        end
      end
      prev_gnt = exp_gnt;
      step;
    end
    idle;
  endtask

  task automatic test_empty_store;
    drive(0, 1'b1, 4'hF, 8'h30, 32'h0000_0055);
    step; idle;
    drive(1, 1'b1, 4'h0, 8'h30, 32'hFFFF_FFFF);
    #1;
    tests++;
    if ({gnt, mem_en, mem_wr} !== {2'b10, 1'b0, 1'b0}) begin
      fails++; $display("FAIL empty_store_cmd: gnt=%b en=%b wr=%b required 10 0 0", gnt, mem_en, mem_wr);
    end
    step; idle;
    tests++;
    if ({rvalid, rdata} !== {2'b10, 32'h0}) begin
      fails++; $display("FAIL empty_store_resp: rvalid=%b rdata=%h required 10 0", rvalid, rdata);
    end
    tests++;
    if (tb_mem[8'h30] !== 32'h0000_0055) begin
      fails++; $display("FAIL empty_store_word: got %h required 00000055", tb_mem[8'h30]);
    end
  endtask

  task automatic test_back_to_back;
    drive(0, 1'b1, 4'hF, 8'h40, 32'h1234_5678);
    #1;
    tests++;
    if (gnt !== 2'b01) begin
      fails++; $display("FAIL b2b_store_gnt: got %b required 01", gnt);
    end
    step;
    drive(0, 1'b0, 4'h0, 8'h40, 32'h0);
    #1;
    tests++;
    if ({rvalid, gnt, mem_en, mem_wr, mem_addr} !== {2'b01, 2'b01, 1'b1, 1'b0, 8'h40}) begin
      fails++; $display("FAIL b2b_load_cmd: rvalid=%b gnt=%b en=%b wr=%b addr=%h required 01 01 1 0 40",
                        rvalid, gnt, mem_en, mem_wr, mem_addr);
    end
    step; idle;
    tests++;
    if ({rvalid, rdata} !== {2'b01, 32'h1234_5678}) begin
      fails++; $display("FAIL b2b_load_resp: rvalid=%b rdata=%h required 01 12345678", rvalid, rdata);
    end
  endtask

  task automatic test_reset_in_rmw;
    // Port 0 starts the RMW so a surviving RR pointer would favour port 1.
    drive(0, 1'b1, 4'b0011, 8'h40, 32'hCAFE_F00D);
    step; idle;
    rst = 1'b1;
    drive(0, 1'b0, 4'h0, 8'h10, 32'h0);
    drive(1, 1'b0, 4'h0, 8'h20, 32'h0);
    #1;
    tests++;
    if ({gnt, rvalid, mem_en, mem_wr, mem_addr, mem_wdata, rdata} !== 78'd0) begin
      fails++; $display("FAIL rst_rmw_outputs: gnt=%b rvalid=%b en=%b wr=%b addr=%h wdata=%h rdata=%h required all 0",
                        gnt, rvalid, mem_en, mem_wr, mem_addr, mem_wdata, rdata);
    end
    step;
    tests++;
    if ({rvalid, tb_mem[8'h40]} !== {2'b00, 32'h1234_5678}) begin
      fails++; $display("FAIL rst_rmw_word: rvalid=%b word=%h required 00 12345678", rvalid, tb_mem[8'h40]);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (gnt !== 2'b01) begin
      fails++; $display("FAIL rst_first_gnt: got %b required 01", gnt);
    end
    step; idle;
    tests++;
    if ({rvalid, rdata} !== {2'b01, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL rst_first_resp: rvalid=%b rdata=%h required 01 deadbeef", rvalid, rdata);
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    be    = '0;
    addr  = '0;
    wdata = '0;
    test_reset;
    test_load_after_store;
    test_partial_store;
    test_contention;
    test_empty_store;
    test_back_to_back;
    test_reset_in_rmw;
    step;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
